// File: rtl/heart_damage.sv
// heart_damage: latches heart/bullet overlap per video frame, applies damage
// with invincibility frames, and drives hp, blink enable and game-over.
module heart_damage (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [3:0] status,
    input  logic       is_heart,
    input  logic       is_bullet,
    output logic [7:0] hp,
    output logic       damage_pulse,
    output logic       heart_visible,
    output logic       game_over
);

    localparam int unsigned HP_W  = 8;
    localparam int unsigned IFR_W = 6;
    localparam int unsigned ST_W  = 4;

    localparam logic [HP_W-1:0]  HP_MAX  = HP_W'(20);
    localparam logic [HP_W-1:0]  DAMAGE  = HP_W'(3);
    localparam logic [IFR_W-1:0] IFRAMES = IFR_W'(30);
    localparam logic [ST_W-1:0]  BATTLE  = ST_W'(5);
    localparam logic [ST_W-1:0]  TITLE   = ST_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [HP_W-1:0]  hp_nxt;
    logic [IFR_W-1:0] iframe_cnt;
    logic [IFR_W-1:0] iframe_cnt_nxt;
    logic             hit_pending;
    logic             hit_pending_nxt;
    logic             damage_pulse_nxt;
    logic             frame_clk_delayed;
    logic             frame_edge;
    logic             overlap;

    assign overlap = is_heart & is_bullet & (status == BATTLE);

    // Rising-edge detect of the frame clock, one Clk wide
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_clk_delayed <= 1'b0;
            frame_edge        <= 1'b0;
        end else begin
            frame_clk_delayed <= frame_clk;
            frame_edge        <= frame_clk & ~frame_clk_delayed;
        end
    end

    // State, hit-point and invincibility registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            hp           <= HP_MAX;
            iframe_cnt   <= '0;
            hit_pending  <= 1'b0;
            damage_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            hp           <= hp_nxt;
            iframe_cnt   <= iframe_cnt_nxt;
            hit_pending  <= hit_pending_nxt;
            damage_pulse <= damage_pulse_nxt;
        end
    end

    // Next-state: title reload beats leaving battle, which beats frame events
    always_comb begin
        state_nxt        = state;
        hp_nxt           = hp;
        iframe_cnt_nxt   = iframe_cnt;
        damage_pulse_nxt = 1'b0;
        hit_pending_nxt  = hit_pending;

        // an overlap during the edge cycle is discarded with the clear
        if (overlap) begin
            hit_pending_nxt = 1'b1;
        end
        if (frame_edge) begin
            hit_pending_nxt = 1'b0;
        end

        if (status == TITLE) begin
            state_nxt       = IDLE;
            hp_nxt          = HP_MAX;
            iframe_cnt_nxt  = '0;
            hit_pending_nxt = 1'b0;
        end else if ((state != DEAD) && (status != BATTLE)) begin
            state_nxt       = IDLE;
            iframe_cnt_nxt  = '0;
            hit_pending_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = ARMED;
                end
                ARMED: begin
                    if (frame_edge && hit_pending) begin
                        damage_pulse_nxt = 1'b1;
                        if (hp > DAMAGE) begin
                            hp_nxt         = hp - DAMAGE;
                            state_nxt      = INVULN;
                            iframe_cnt_nxt = IFRAMES;
                        end else begin
                            hp_nxt         = '0;
                            state_nxt      = DEAD;
                        end
                    end
                end
                INVULN: begin
                    if (frame_edge) begin
                        if (iframe_cnt == IFR_W'(1)) begin
                            state_nxt      = ARMED;
                            iframe_cnt_nxt = '0;
                        end else begin
                            iframe_cnt_nxt = iframe_cnt - IFR_W'(1);
                        end
                    end
                end
                DEAD: begin
                    state_nxt = DEAD;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Blink off during every other group of four invincible frames
    assign heart_visible = ~((state == INVULN) & iframe_cnt[2]);
    assign game_over     = (state == DEAD);

endmodule

// File: tb/tb_heart_damage.sv
// Scoreboard bench for heart_damage: expected hp per damage pulse is queued by
// the stimulus, and a monitor pops and compares on every observed pulse.
`timescale 1ns/1ps
module tb_heart_damage;

    logic       Clk       = 1'b0;
    logic       Reset     = 1'b0;
    logic       frame_clk = 1'b0;
    logic [3:0] status    = 4'd0;
    logic       is_heart  = 1'b0;
    logic       is_bullet = 1'b0;
    logic [7:0] hp;
    logic       damage_pulse;
    logic       heart_visible;
    logic       game_over;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] exp_q[$];
    logic       prev_pulse = 1'b0;

    always #5 Clk = ~Clk;

    heart_damage dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .status       (status),
        .is_heart     (is_heart),
        .is_bullet    (is_bullet),
        .hp           (hp),
        .damage_pulse (damage_pulse),
        .heart_visible(heart_visible),
        .game_over    (game_over)
    );

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic run_frame(input bit hit);
        if (hit) begin
            is_heart  = 1'b1;
            is_bullet = 1'b1;
        end
        tick(1);
        is_heart  = 1'b0;
        is_bullet = 1'b0;
        tick(1);
        frame_clk = 1'b1;
        tick(3);
        frame_clk = 1'b0;
        tick(4);
    endtask

    // Monitor: every damage pulse must match the next queued hp
    always @(negedge Clk) begin
        if (Reset && damage_pulse) begin
            check("pulse_single_cycle", int'(prev_pulse), 0);
            check("pulse_has_expectation", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("hp_on_pulse", int'(hp), int'(e));
            end
        end
        prev_pulse <= Reset & damage_pulse;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] hit_seq[7];

    initial begin
        hit_seq = '{8'd17, 8'd14, 8'd11, 8'd8, 8'd5, 8'd2, 8'd0};

        // reset values
        tick(2);
        check("rst_hp", int'(hp), 20);
        check("rst_pulse", int'(damage_pulse), 0);
        check("rst_visible", int'(heart_visible), 1);
        check("rst_game_over", int'(game_over), 0);

        // first hit with cycle-accurate latency
        Reset  = 1'b1;
        status = 4'd5;
        tick(2);
        exp_q.push_back(8'd17);
        is_heart = 1'b1; is_bullet = 1'b1;
        tick(1);
        is_heart = 1'b0; is_bullet = 1'b0;
        tick(1);
        frame_clk = 1'b1;
        tick(1);
        check("hp_one_edge_after_rise", int'(hp), 20);
        check("pulse_one_edge_after_rise", int'(damage_pulse), 0);
        tick(1);
        check("hp_two_edges_after_rise", int'(hp), 17);
        check("pulse_two_edges_after_rise", int'(damage_pulse), 1);
        check("visible_iframe30", int'(heart_visible), 0);
        tick(1);
        check("pulse_drops", int'(damage_pulse), 0);
        frame_clk = 1'b0;
        tick(4);

        // blink: counter 29,28,27 -> visible at 27; 23 -> hidden
        run_frame(0);
        check("visible_iframe29", int'(heart_visible), 0);
        run_frame(0);
        run_frame(0);
        check("visible_iframe27", int'(heart_visible), 1);
        repeat (4) run_frame(0);
        check("visible_iframe23", int'(heart_visible), 0);

        // leaving battle during invincibility
        status = 4'd3;
        tick(1);
        check("nonbattle_visible", int'(heart_visible), 1);
        check("nonbattle_hp", int'(hp), 17);
        check("nonbattle_game_over", int'(game_over), 0);
        status = 4'd5;
        tick(2);
        exp_q.push_back(8'd14);
        run_frame(1);
        check("rearmed_hit_hp", int'(hp), 14);
        check("invuln_hidden_before_reset", int'(heart_visible), 0);

        // async reset mid-invincibility, no clock edge
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_hp", int'(hp), 20);
        check("async_rst_pulse", int'(damage_pulse), 0);
        check("async_rst_visible", int'(heart_visible), 1);
        check("async_rst_game_over", int'(game_over), 0);
        tick(2);
        Reset = 1'b1;
        tick(2);

        // overlap in every frame for 35 frames
        for (int f = 1; f <= 35; f++) begin
            if (f == 1)  exp_q.push_back(8'd17);
            if (f == 32) exp_q.push_back(8'd14);
            run_frame(1);
            if (f == 31) check("hp_after_frame31", int'(hp), 17);
        end
        check("hp_after_frame35", int'(hp), 14);

        // seven spaced hits down to zero
        Reset = 1'b0;
        tick(1);
        Reset = 1'b1;
        tick(2);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(hit_seq[i]);
            run_frame(1);
            check($sformatf("spaced_hit%0d_hp", i), int'(hp), int'(hit_seq[i]));
            if (i < 6) repeat (30) run_frame(0);
        end
        check("dead_game_over", int'(game_over), 1);
        check("dead_visible", int'(heart_visible), 1);
        repeat (3) run_frame(1);
        check("dead_hp_stays_zero", int'(hp), 0);
        status = 4'd3;
        tick(2);
        check("dead_ignores_nonbattle", int'(game_over), 1);

        // return to title
        status = 4'd0;
        tick(1);
        check("title_hp", int'(hp), 20);
        check("title_game_over", int'(game_over), 0);
        status = 4'd5;
        tick(2);

        // overlap only during the frame_edge cycle is dropped
        frame_clk = 1'b1;
        tick(1);
        is_heart = 1'b1; is_bullet = 1'b1;
        tick(1);
        is_heart = 1'b0; is_bullet = 1'b0;
        tick(1);
        frame_clk = 1'b0;
        tick(4);
        run_frame(0);
        check("edge_overlap_dropped", int'(hp), 20);
        exp_q.push_back(8'd17);
        run_frame(1);
        check("armed_after_title", int'(hp), 17);

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
